// File: rtl/vend_pkg.sv
// Shared coin codes, FSM state encoding and coin helpers for the multi-product vending controller.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam int unsigned COIN_VAL_W = 5;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2
  } state_t;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      COIN_20: return 5'd20;
      default: return 5'd0;
    endcase
  endfunction

  // Greedy pick: largest coin not exceeding the remaining credit.
  function automatic logic [1:0] largest_coin(input logic [31:0] bal);
    if (bal >= 32'd20)      return COIN_20;
    else if (bal >= 32'd10) return COIN_10;
    else if (bal >= 32'd5)  return COIN_5;
    else                    return COIN_NONE;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Combinational greedy change picker: coin code and value of the next change coin.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int unsigned BAL_W = 8
) (
  input  logic [BAL_W-1:0] i_balance,
  output logic [1:0]       o_change_coin,
  output logic [BAL_W-1:0] o_coin_val
);

  logic [1:0] w_coin;

  assign w_coin        = largest_coin(32'(i_balance));
  assign o_change_coin = w_coin;
  assign o_coin_val    = BAL_W'(coin_value(w_coin));

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product coin vending controller: collects credit, vends by index, pays back
// change one coin per cycle (largest first), supports cancel/refund and overflow reject.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned              BAL_W       = 8,
  parameter int unsigned              N_PROD      = 4,
  parameter int unsigned              SEL_W       = 2,
  parameter logic [N_PROD*BAL_W-1:0]  PRICES      = {8'd40, 8'd25, 8'd10, 8'd15},
  parameter bit                       AUTO_CHANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid,
  input  logic [1:0]       coin,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             cancel,
  output logic [BAL_W-1:0] balance,
  output logic             busy,
  output logic             coin_reject,
  output logic             sel_err,
  output logic             vend_valid,
  output logic [SEL_W-1:0] vend_id,
  output logic             change_valid,
  output logic [1:0]       change_coin
);

  function automatic bit prices_ok();
    logic [BAL_W-1:0] p;
    for (int unsigned i = 0; i < N_PROD; i++) begin
      p = PRICES[i*BAL_W +: BAL_W];
      if (p == '0 || (p % BAL_W'(5)) != '0) return 1'b0;
    end
    return 1'b1;
  endfunction

  if (!prices_ok()) begin : g_bad_prices
    $error("vend_ctrl_multi: every price must be a nonzero multiple of 5");
  end
  if ((2 ** SEL_W) < N_PROD || N_PROD < 1) begin : g_bad_sel_w
    $error("vend_ctrl_multi: need N_PROD >= 1 and 2**SEL_W >= N_PROD");
  end

  state_t           r_state;
  logic [BAL_W-1:0] r_balance;
  logic             r_busy;
  logic             r_coin_reject;
  logic             r_sel_err;
  logic             r_vend_valid;
  logic [SEL_W-1:0] r_vend_id;
  logic             r_change_valid;
  logic [1:0]       r_change_coin;

  logic [BAL_W-1:0] w_coin_val;
  logic [BAL_W:0]   w_sum;
  logic             w_coin_nz;
  logic             w_coin_fit;
  logic [BAL_W-1:0] w_bal_post;
  logic             w_sel_ok;
  logic [SEL_W-1:0] w_sel_idx;
  logic [BAL_W-1:0] w_price;
  logic [BAL_W-1:0] w_chg_src;
  logic [1:0]       w_chg_coin;
  logic [BAL_W-1:0] w_chg_val;
  logic [BAL_W-1:0] w_chg_rem;
  logic             w_chg_more;

  // Coin add is one bit wider so an overflowing coin can be detected and bounced.
  assign w_coin_val = BAL_W'(coin_value(coin));
  assign w_sum      = {1'b0, r_balance} + (BAL_W+1)'(w_coin_val);
  assign w_coin_nz  = coin_valid && (coin != COIN_NONE);
  assign w_coin_fit = !w_sum[BAL_W];
  assign w_bal_post = (w_coin_nz && w_coin_fit) ? w_sum[BAL_W-1:0] : r_balance;

  assign w_sel_ok  = (32'(sel) < N_PROD);
  assign w_sel_idx = w_sel_ok ? sel : '0;
  assign w_price   = PRICES[32'(w_sel_idx)*BAL_W +: BAL_W];

  // A refund from COLLECT pays out of the post-coin credit; otherwise the stored credit.
  assign w_chg_src  = (r_state == ST_COLLECT) ? w_bal_post : r_balance;
  assign w_chg_rem  = w_chg_src - w_chg_val;
  assign w_chg_more = (w_chg_rem != '0);

  vend_change_gen #(.BAL_W(BAL_W)) u_change_gen (
    .i_balance     (w_chg_src),
    .o_change_coin (w_chg_coin),
    .o_coin_val    (w_chg_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_COLLECT;
      r_balance      <= '0;
      r_busy         <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_sel_err      <= 1'b0;
      r_vend_valid   <= 1'b0;
      r_vend_id      <= '0;
      r_change_valid <= 1'b0;
      r_change_coin  <= COIN_NONE;
    end else begin
      r_coin_reject  <= 1'b0;
      r_sel_err      <= 1'b0;
      r_vend_valid   <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= COIN_NONE;
      case (r_state)
        ST_COLLECT: begin
          r_balance     <= w_bal_post;
          r_coin_reject <= w_coin_nz && !w_coin_fit;
          if (cancel) begin
            if (w_bal_post != '0) begin
              r_change_valid <= 1'b1;
              r_change_coin  <= w_chg_coin;
              r_balance      <= w_chg_rem;
              r_state        <= w_chg_more ? ST_CHANGE : ST_COLLECT;
              r_busy         <= w_chg_more;
            end
          end else if (sel_valid) begin
            if (!w_sel_ok || (w_bal_post < w_price)) begin
              r_sel_err <= 1'b1;
            end else begin
              r_balance    <= w_bal_post - w_price;
              r_vend_id    <= sel;
              r_vend_valid <= 1'b1;
              r_state      <= ST_VEND;
              r_busy       <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          r_coin_reject <= w_coin_nz;
          if (AUTO_CHANGE && (r_balance != '0)) begin
            r_change_valid <= 1'b1;
            r_change_coin  <= w_chg_coin;
            r_balance      <= w_chg_rem;
            r_state        <= w_chg_more ? ST_CHANGE : ST_COLLECT;
            r_busy         <= w_chg_more;
          end else begin
            r_state <= ST_COLLECT;
            r_busy  <= 1'b0;
          end
        end
        ST_CHANGE: begin
          r_coin_reject <= w_coin_nz;
          if (r_balance != '0) begin
            r_change_valid <= 1'b1;
            r_change_coin  <= w_chg_coin;
            r_balance      <= w_chg_rem;
            r_state        <= w_chg_more ? ST_CHANGE : ST_COLLECT;
            r_busy         <= w_chg_more;
          end else begin
            r_state <= ST_COLLECT;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_COLLECT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign balance      = r_balance;
  assign busy         = r_busy;
  assign coin_reject  = r_coin_reject;
  assign sel_err      = r_sel_err;
  assign vend_valid   = r_vend_valid;
  assign vend_id      = r_vend_id;
  assign change_valid = r_change_valid;
  assign change_coin  = r_change_coin;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: one auto-change instance and one credit-keeping instance.
module tb_vend_ctrl_multi;

  typedef struct packed {
    logic       rej;
    logic       err;
    logic       vv;
    logic [1:0] vid;
    logic       cv;
    logic [1:0] cc;
    logic [7:0] bal;
    logic       busy;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_cv, a_sv, a_cn;
  logic [1:0] a_coin, a_sel;
  logic [7:0] a_bal;
  logic       a_busy, a_rej, a_err, a_vv, a_chv;
  logic [1:0] a_vid, a_chc;

  logic       b_cv, b_sv, b_cn;
  logic [1:0] b_coin, b_sel;
  logic [7:0] b_bal;
  logic       b_busy, b_rej, b_err, b_vv, b_chv;
  logic [1:0] b_vid, b_chc;

  vend_ctrl_multi dut_a (
    .clk(clk), .rst(rst), .coin_valid(a_cv), .coin(a_coin), .sel_valid(a_sv), .sel(a_sel),
    .cancel(a_cn), .balance(a_bal), .busy(a_busy), .coin_reject(a_rej), .sel_err(a_err),
    .vend_valid(a_vv), .vend_id(a_vid), .change_valid(a_chv), .change_coin(a_chc)
  );

  vend_ctrl_multi #(.AUTO_CHANGE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .coin_valid(b_cv), .coin(b_coin), .sel_valid(b_sv), .sel(b_sel),
    .cancel(b_cn), .balance(b_bal), .busy(b_busy), .coin_reject(b_rej), .sel_err(b_err),
    .vend_valid(b_vv), .vend_id(b_vid), .change_valid(b_chv), .change_coin(b_chc)
  );

  int checks = 0;
  int errors = 0;
  snap_t q_a[$];
  snap_t q_b[$];

  function automatic snap_t mk(input logic rej, input logic err, input logic vv,
                               input logic [1:0] vid, input logic cv, input logic [1:0] cc,
                               input logic [7:0] bal, input logic busy);
    snap_t s;
    s = '{rej: rej, err: err, vv: vv, vid: vid, cv: cv, cc: cc, bal: bal, busy: busy};
    return s;
  endfunction

  // vend_id / change_coin only carry meaning while their strobe is high.
  function automatic bit match(input snap_t got, input snap_t exp);
    snap_t g;
    g = got;
    if (!exp.vv) g.vid = exp.vid;
    if (!exp.cv) g.cc  = exp.cc;
    return g === exp;
  endfunction

  always @(negedge clk) begin : mon_a
    snap_t got, exp;
    if (a_rej || a_err || a_vv || a_chv) begin
      got = mk(a_rej, a_err, a_vv, a_vid, a_chv, a_chc, a_bal, a_busy);
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_pulse got %h expected no pulse", got);
      end else begin
        exp = q_a.pop_front();
        if (!match(got, exp)) begin
          errors++;
          $display("FAIL a_event got %h expected %h", got, exp);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    snap_t got, exp;
    if (b_rej || b_err || b_vv || b_chv) begin
      got = mk(b_rej, b_err, b_vv, b_vid, b_chv, b_chc, b_bal, b_busy);
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_pulse got %h expected no pulse", got);
      end else begin
        exp = q_b.pop_front();
        if (!match(got, exp)) begin
          errors++;
          $display("FAIL b_event got %h expected %h", got, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_a(input logic cv, input logic [1:0] c, input logic sv,
                         input logic [1:0] s, input logic cn);
    a_cv = cv; a_coin = c; a_sv = sv; a_sel = s; a_cn = cn;
    @(negedge clk);
    a_cv = 1'b0; a_coin = 2'b00; a_sv = 1'b0; a_sel = 2'b00; a_cn = 1'b0;
  endtask

  task automatic drive_b(input logic cv, input logic [1:0] c, input logic sv,
                         input logic [1:0] s, input logic cn);
    b_cv = cv; b_coin = c; b_sv = sv; b_sel = s; b_cn = cn;
    @(negedge clk);
    b_cv = 1'b0; b_coin = 2'b00; b_sv = 1'b0; b_sel = 2'b00; b_cn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_cv = 1'b0; a_coin = 2'b00; a_sv = 1'b0; a_sel = 2'b00; a_cn = 1'b0;
    b_cv = 1'b0; b_coin = 2'b00; b_sv = 1'b0; b_sel = 2'b00; b_cn = 1'b0;
    idle(2);
    chk("reset_balance", int'(a_bal), 0);
    chk("reset_busy", int'(a_busy), 0);
    chk("reset_pulses", int'({a_rej, a_err, a_vv, a_chv}), 0);
    rst = 1'b0;
    idle(1);

    // 10 + 10, buy product 0 (15): vend, then one 5 coin back
    q_a.push_back(mk(0, 0, 1, 2'd0, 0, 2'b00, 8'd5, 1));
    q_a.push_back(mk(0, 0, 0, 2'd0, 1, 2'b01, 8'd0, 0));
    drive_a(1, 2'b10, 0, 0, 0);
    drive_a(1, 2'b10, 0, 0, 0);
    idle(0);
    chk("bal_after_two_10s", int'(a_bal), 20);
    drive_a(0, 2'b00, 1, 2'd0, 0);
    idle(3);
    chk("bal_after_vend0", int'(a_bal), 0);
    chk("busy_after_vend0", int'(a_busy), 0);

    // Insufficient funds then cancel
    q_a.push_back(mk(0, 1, 0, 2'd0, 0, 2'b00, 8'd5, 0));
    q_a.push_back(mk(0, 0, 0, 2'd0, 1, 2'b01, 8'd0, 0));
    drive_a(1, 2'b01, 0, 0, 0);
    drive_a(0, 2'b00, 1, 2'd2, 0);
    chk("bal_after_sel_err", int'(a_bal), 5);
    drive_a(0, 2'b00, 0, 0, 1);
    idle(2);
    chk("bal_after_refund5", int'(a_bal), 0);

    // Coin code 00 and cancel at zero credit do nothing
    drive_a(1, 2'b00, 0, 0, 0);
    drive_a(0, 2'b00, 0, 0, 1);
    idle(2);
    chk("idle_busy", int'(a_busy), 0);
    chk("idle_balance", int'(a_bal), 0);

    // Build 240, overflow reject, then 10 -> 250
    for (int i = 0; i < 12; i++) drive_a(1, 2'b11, 0, 0, 0);
    chk("bal_240", int'(a_bal), 240);
    q_a.push_back(mk(1, 0, 0, 2'd0, 0, 2'b00, 8'd240, 0));
    drive_a(1, 2'b11, 0, 0, 0);
    drive_a(1, 2'b10, 0, 0, 0);
    chk("bal_250", int'(a_bal), 250);

    // Refund 250: twelve 20s then a 10; coin during CHANGE bounced, sel ignored
    for (int i = 0; i < 12; i++)
      q_a.push_back(mk(i == 1, 0, 0, 2'd0, 1, 2'b11, 8'(250 - 20 * (i + 1)), 1));
    q_a.push_back(mk(0, 0, 0, 2'd0, 1, 2'b10, 8'd0, 0));
    drive_a(0, 2'b00, 0, 0, 1);
    drive_a(1, 2'b01, 0, 0, 0);
    drive_a(0, 2'b00, 1, 2'd1, 0);
    idle(13);
    chk("bal_after_big_refund", int'(a_bal), 0);
    chk("busy_after_big_refund", int'(a_busy), 0);

    // Same-cycle coin 20 with select of product 1 (10)
    q_a.push_back(mk(0, 0, 1, 2'd1, 0, 2'b00, 8'd10, 1));
    q_a.push_back(mk(0, 0, 0, 2'd0, 1, 2'b10, 8'd0, 0));
    drive_a(1, 2'b11, 1, 2'd1, 0);
    idle(3);
    chk("bal_after_same_cycle", int'(a_bal), 0);

    // Credit-keeping instance: 40, buy product 1, coin during VEND bounced
    drive_b(1, 2'b11, 0, 0, 0);
    drive_b(1, 2'b11, 0, 0, 0);
    q_b.push_back(mk(0, 0, 1, 2'd1, 0, 2'b00, 8'd30, 1));
    q_b.push_back(mk(1, 0, 0, 2'd0, 0, 2'b00, 8'd30, 0));
    q_b.push_back(mk(0, 1, 0, 2'd0, 0, 2'b00, 8'd30, 0));
    drive_b(0, 2'b00, 1, 2'd1, 0);
    drive_b(1, 2'b01, 0, 0, 0);
    idle(1);
    chk("b_bal_kept", int'(b_bal), 30);
    chk("b_busy", int'(b_busy), 0);
    drive_b(0, 2'b00, 1, 2'd3, 0);
    q_b.push_back(mk(0, 0, 0, 2'd0, 1, 2'b11, 8'd10, 1));
    q_b.push_back(mk(0, 0, 0, 2'd0, 1, 2'b10, 8'd0, 0));
    drive_b(0, 2'b00, 0, 0, 1);
    idle(3);
    chk("b_bal_refunded", int'(b_bal), 0);

    // 35 refund interrupted by reset after the second coin
    drive_a(1, 2'b11, 0, 0, 0);
    drive_a(1, 2'b10, 0, 0, 0);
    drive_a(1, 2'b01, 0, 0, 0);
    chk("bal_35", int'(a_bal), 35);
    q_a.push_back(mk(0, 0, 0, 2'd0, 1, 2'b11, 8'd15, 1));
    q_a.push_back(mk(0, 0, 0, 2'd0, 1, 2'b10, 8'd5, 1));
    drive_a(0, 2'b00, 0, 0, 1);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_change_balance", int'(a_bal), 0);
    chk("rst_mid_change_busy", int'(a_busy), 0);
    chk("rst_mid_change_pulses", int'({a_rej, a_err, a_vv, a_chv}), 0);
    idle(4);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
